// File: rtl/nios_memory_arbiter.sv
// Two-master round-robin arbiter in front of a single-port synchronous RAM.
// Optionally zero-fills the RAM after reset before serving any master.
module nios_memory_arbiter #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  input  logic [DATA_W-1:0]     mem_readdata
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_ARB = 1'b1} state_t;

  state_t            state_r, state_next_s;
  logic [ADDR_W-1:0] clr_cnt_r;
  logic              last_gnt_r;   // 1: master 1 was granted most recently
  logic              rd_pend_r;
  logic              rd_owner_r;
  logic              req0_s, req1_s, gnt0_s, gnt1_s, gnt_s, gnt_rd_s;

  // Request decode and round-robin grant, only while serving masters.
  always_comb begin
    req0_s = m0_read | m0_write;
    req1_s = m1_read | m1_write;
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!reset && state_r == ST_ARB) begin
      if (req0_s && req1_s) begin
        gnt0_s = last_gnt_r;
        gnt1_s = ~last_gnt_r;
      end else begin
        gnt0_s = req0_s;
        gnt1_s = req1_s;
      end
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
    gnt_s    = gnt0_s | gnt1_s;
    // a simultaneous read+write is a write, so only a pure read expects data
    gnt_rd_s = gnt1_s ? ~m1_write : (gnt0_s & ~m0_write);
  end

  // Next-state logic: fill ends on the cycle the last word is written.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_cnt_r == ADDR_LAST) state_next_s = ST_ARB;
        else                        state_next_s = ST_CLEAR;
      end
      ST_ARB:  state_next_s = ST_ARB;
      default: state_next_s = ST_CLEAR;
    endcase
  end

  // RAM port and waitrequest steering.
  always_comb begin
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = clr_cnt_r;
    mem_byteenable = {BE_W{1'b1}};
    mem_writedata  = {DATA_W{1'b0}};
    if (reset) begin
      mem_chipselect = 1'b0;
    end else if (state_r == ST_CLEAR) begin
      mem_chipselect = 1'b1;
      mem_write      = 1'b1;
    end else begin
      m0_waitrequest = req0_s & ~gnt0_s;
      m1_waitrequest = req1_s & ~gnt1_s;
      mem_chipselect = gnt_s;
      if (gnt1_s) begin
        mem_address    = m1_address;
        mem_byteenable = m1_byteenable;
        mem_writedata  = m1_writedata;
        mem_write      = m1_write;
      end else if (gnt0_s) begin
        mem_address    = m0_address;
        mem_byteenable = m0_byteenable;
        mem_writedata  = m0_writedata;
        mem_write      = m0_write;
      end else begin
        mem_write      = 1'b0;
      end
    end
  end

  // State, fill counter, round-robin pointer and pending-read tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_ARB;
      clr_cnt_r  <= {ADDR_W{1'b0}};
      last_gnt_r <= 1'b1;
      rd_pend_r  <= 1'b0;
      rd_owner_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (state_r == ST_CLEAR && clr_cnt_r != ADDR_LAST) clr_cnt_r <= clr_cnt_r + ADDR_ONE;
      else                                                clr_cnt_r <= clr_cnt_r;
      if (gnt_s) last_gnt_r <= gnt1_s;
      else       last_gnt_r <= last_gnt_r;
      rd_pend_r  <= gnt_rd_s;
      rd_owner_r <= gnt1_s;
    end
  end

  // A read in flight when reset arrives must not produce a valid pulse.
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rd_pend_r & ~rd_owner_r & ~reset;
  assign m1_readdatavalid = rd_pend_r &  rd_owner_r & ~reset;

endmodule

// File: tb/tb_nios_memory_arbiter.sv
// Bench for nios_memory_arbiter: behavioural RAM, cycle-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_nios_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  m0_address, m1_address, mem_address;
  logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata, mem_writedata;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata, mem_readdata;
  logic        mem_chipselect, mem_write;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nios_memory_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_readdata(mem_readdata)
  );

  function automatic logic [31:0] pat(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural RAM, preloaded with a non-zero pattern so the fill is visible.
  logic [31:0] ram [1024];
  logic [31:0] ram_rdata = 32'h0;
  assign mem_readdata = ram_rdata;
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = pat(i);
    forever begin
      @(posedge clk);
      if (mem_chipselect === 1'b1) begin
        ram_rdata <= ram[mem_address];
        if (mem_write === 1'b1)
          for (int b = 0; b < 4; b++)
            if (mem_byteenable[b]) ram[mem_address][8*b +: 8] = mem_writedata[8*b +: 8];
      end
    end
  end

  // Reference model: memory image, fill position, last grantee, pending read.
  logic [31:0] ref_mem [1024];
  initial begin
    bit in_clear, pv, r0, r1, wr;
    int fill, last_gnt, pm, g;
    logic [31:0] pd, d;
    logic [9:0]  a;
    logic [3:0]  be;
    for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
    in_clear = 1'b1; fill = 0; last_gnt = 1; pv = 1'b0; pm = 0; pd = 32'h0;
    forever begin
      @(negedge clk);
      check("m0_rdvalid", m0_readdatavalid, pv && pm == 0 && !reset);
      check("m1_rdvalid", m1_readdatavalid, pv && pm == 1 && !reset);
      if (pv && !reset && pm == 0) check("m0_rddata", m0_readdata, pd);
      if (pv && !reset && pm == 1) check("m1_rddata", m1_readdata, pd);
      pv = 1'b0;
      if (reset) begin
        check("rst_cs", mem_chipselect, 1'b0);
        check("rst_we", mem_write, 1'b0);
        check("rst_w0", m0_waitrequest, 1'b1);
        check("rst_w1", m1_waitrequest, 1'b1);
        in_clear = 1'b1; fill = 0; last_gnt = 1;
      end else if (in_clear) begin
        check("clr_cs", mem_chipselect, 1'b1);
        check("clr_we", mem_write, 1'b1);
        check("clr_addr", mem_address, fill);
        check("clr_be", mem_byteenable, 4'hF);
        check("clr_data", mem_writedata, 32'h0);
        check("clr_w0", m0_waitrequest, 1'b1);
        check("clr_w1", m1_waitrequest, 1'b1);
        ref_mem[fill] = 32'h0;
        if (fill == 1023) in_clear = 1'b0;
        else              fill++;
      end else begin
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        if (r0 && r1) g = (last_gnt == 0) ? 1 : 0;
        else if (r0)  g = 0;
        else if (r1)  g = 1;
        else          g = -1;
        check("arb_w0", m0_waitrequest, r0 && g != 0);
        check("arb_w1", m1_waitrequest, r1 && g != 1);
        check("arb_cs", mem_chipselect, g >= 0);
        if (g >= 0) begin
          a  = (g == 1) ? m1_address    : m0_address;
          wr = (g == 1) ? m1_write      : m0_write;
          d  = (g == 1) ? m1_writedata  : m0_writedata;
          be = (g == 1) ? m1_byteenable : m0_byteenable;
          check("arb_we", mem_write, wr);
          check("arb_addr", mem_address, a);
          check("arb_be", mem_byteenable, be);
          check("arb_wdata", mem_writedata, d);
          if (wr) begin
            for (int b = 0; b < 4; b++)
              if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
          end else begin
            pv = 1'b1; pm = g; pd = ref_mem[a];
          end
          last_gnt = g;
        end else begin
          check("arb_we_idle", mem_write, 1'b0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pick(output logic rd, output logic wr, output logic [9:0] a,
                      output logic [31:0] d, output logic [3:0] be);
    int k;
    k  = $urandom_range(0, 5);
    rd = (k == 2 || k == 3 || k == 5);
    wr = (k == 4 || k == 5);
    a  = 10'($urandom_range(0, 15));
    d  = $urandom;
    be = 4'($urandom_range(0, 15));
  endtask

  // Hold m0_read until granted, checking the full fill length before it.
  task automatic wait_fill_then_read(input string tag);
    int cnt;
    cnt = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (!m0_waitrequest) break;
      if (cnt == 0) check({tag, "_first_addr"}, mem_address, 10'd0);
      cnt++;
    end
    check({tag, "_fill_len"}, cnt, 1024);
    tick();
    m0_read = 1'b0;
    @(negedge clk);
    check({tag, "_rdv"}, m0_readdatavalid, 1'b1);
    check({tag, "_data"}, m0_readdata, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    bit acc0, acc1;
    reset = 1'b1;
    m0_read = 1'b0; m0_write = 1'b0; m0_address = 10'd0; m0_writedata = 32'h0; m0_byteenable = 4'h0;
    m1_read = 1'b0; m1_write = 1'b0; m1_address = 10'd0; m1_writedata = 32'h0; m1_byteenable = 4'h0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_cs", mem_chipselect, 1'b0);
    check("reset_wait0", m0_waitrequest, 1'b1);

    // Fill after reset, then the first read returns zero.
    tick();
    reset = 1'b0; m0_read = 1'b1; m0_address = 10'd5;
    wait_fill_then_read("fill1");

    // m0 write then m1 read of the same word on the next cycle.
    tick();
    m0_write = 1'b1; m0_address = 10'd3; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
    tick();
    m0_write = 1'b0; m1_read = 1'b1; m1_address = 10'd3;
    tick();
    m1_read = 1'b0;
    @(negedge clk);
    check("wr_rd_m1_rdv", m1_readdatavalid, 1'b1);
    check("wr_rd_m1_data", m1_readdata, 32'hDEADBEEF);
    check("wr_rd_m0_rdv", m0_readdatavalid, 1'b0);

    // Partial byte-enable write over zero.
    tick();
    m0_write = 1'b1; m0_address = 10'd7; m0_writedata = 32'h11223344; m0_byteenable = 4'b0101;
    tick();
    m0_write = 1'b0; m0_read = 1'b1;
    tick();
    m0_read = 1'b0;
    @(negedge clk);
    check("be_rdv", m0_readdatavalid, 1'b1);
    check("be_data", m0_readdata, 32'h00220044);

    // Continuous contention: m0 was last granted, so m1 wins first, then alternate.
    tick();
    m0_read = 1'b1; m0_address = 10'd10; m1_read = 1'b1; m1_address = 10'd20;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("alt_w0", m0_waitrequest, (i % 2 == 0));
      check("alt_w1", m1_waitrequest, (i % 2 == 1));
      if (i > 0) check("alt_one_valid", 32'(m0_readdatavalid) + 32'(m1_readdatavalid), 32'd1);
    end
    tick();
    m0_read = 1'b0; m1_read = 1'b0;

    // Reset the cycle after an m1 read grant: no valid pulse.
    tick();
    m1_read = 1'b1; m1_address = 10'd20;
    tick();
    m1_read = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("rst_kill_rdv", m1_readdatavalid, 1'b0);

    // Reset at fill position 500 restarts the fill from 0.
    tick();
    reset = 1'b0;
    check("refill_start", mem_address, 10'd0);
    repeat (500) tick();
    check("refill_500", mem_address, 10'd500);
    reset = 1'b1;
    tick();
    reset = 1'b0; m0_read = 1'b1; m0_address = 10'd5;
    wait_fill_then_read("fill2");

    // Randomized traffic; a master holds its request until accepted.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc0 = !(m0_read || m0_write) || !m0_waitrequest;
      acc1 = !(m1_read || m1_write) || !m1_waitrequest;
      tick();
      if (acc0) pick(m0_read, m0_write, m0_address, m0_writedata, m0_byteenable);
      if (acc1) pick(m1_read, m1_write, m1_address, m1_writedata, m1_byteenable);
    end
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
